prng_p2s: RTL and testbench

//  Parallel-to-serial converter directly downstream of the PRNG core. Captures each random

---
 rtl/prng_pkg.sv | 17 +
 rtl/prng_p2s_baud_tick.sv | 36 +++
 rtl/prng_p2s.sv | 179 +++++++++++++++++
 tb/tb_prng_p2s.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG output path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prng_pkg;

    // Width of the PRNG rand word.
    localparam int PRNG_WIDTH = 32;

    // Serializer states. PAR is only ever entered when parity is built in
    // (P2S_PARITY_EN).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } p2s_state_t;

endpackage

// File: rtl/prng_p2s_baud_tick.sv
// Bit-period divider for the serializer: emits a 1-cycle tick every CLK_DIV cycles.
// Latency: tick asserts combinationally in the last cycle of each bit period.
// Backpressure: none; the counter free-runs while en is high and restarts on clr.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   en        count enable (serializer busy)
//   clr       restart the bit period (a new frame is being loaded)
//   tick      high in the final cycle of the current bit period
module p2s_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A 1-bit counter is kept even for CLK_DIV=1; it simply sits at zero.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/prng_p2s.sv
// Parallel-to-serial converter behind the PRNG core, with a 1-word holding buffer.
// Latency: din_valid -> first serial bit 1 cycle; each bit lasts CLK_DIV cycles.
// Backpressure: p2s_ready = !hold_full; a strobe while not ready is dropped and sets overflow.
//
// Build option: define P2S_PARITY_EN to append one even-parity bit (PAR state) per frame.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   din         parallel word from the PRNG
//   din_valid   one-cycle strobe qualifying din
//   p2s_ready   a word can be accepted this cycle (holding buffer empty)
//   sout        serial data bit
//   sout_valid  sout carries a frame bit
//   sof         first bit period of each frame
//   busy        serializer is in SHIFT or PAR
//   overflow    sticky: a word was dropped because the buffer was full
module prng_p2s
    import prng_pkg::*;
#(
    parameter int WIDTH     = PRNG_WIDTH,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             p2s_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             busy,
    output logic             overflow
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    p2s_state_t       state;
    p2s_state_t       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold;
    logic             hold_vld;
    logic [BW-1:0]    bit_cnt;
    logic             ovf;
`ifdef P2S_PARITY_EN
    logic             par_bit;
`endif

    logic             tick;
    logic             last_bit;
    logic             frame_end;
    logic             shift_en;
    logic             load_hold;
    logic             load_din;
    logic             load;
    logic             hold_wr;
    logic [WIDTH-1:0] load_word;
    logic             data_bit;

    p2s_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (busy),
        .clr  (load),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        frame_end = 1'b0;
        shift_en  = 1'b0;
        last_bit  = (bit_cnt == LAST_BIT);

        case (state)
            IDLE: begin
                if (din_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (last_bit) begin
`ifdef P2S_PARITY_EN
                        state_nxt = PAR;
`else
                        frame_end = 1'b1;
`endif
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
`ifdef P2S_PARITY_EN
            PAR: begin
                if (tick) begin
                    frame_end = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase

        // At the end of a frame a waiting word has priority; with the buffer
        // empty a strobe in the very same cycle goes straight to the shifter.
        load_hold = frame_end && hold_vld;
        load_din  = din_valid && !hold_vld && ((state == IDLE) || frame_end);
        load      = load_hold || load_din;
        load_word = load_hold ? hold : din;

        if (frame_end) begin
            state_nxt = load ? SHIFT : IDLE;
        end

        hold_wr = din_valid && !hold_vld && (state != IDLE) && !frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
            bit_cnt  <= '0;
            ovf      <= 1'b0;
`ifdef P2S_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            if (load) begin
                shreg   <= load_word;
                bit_cnt <= '0;
`ifdef P2S_PARITY_EN
                par_bit <= ^load_word;
`endif
            end else if (shift_en) begin
                shreg   <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (hold_wr) begin
                hold     <= din;
                hold_vld <= 1'b1;
            end else if (load_hold) begin
                hold_vld <= 1'b0;
            end

            // Covers the drain cycle too: hold_vld is still set then.
            if (din_valid && hold_vld) begin
                ovf <= 1'b1;
            end
        end
    end

    assign data_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign busy       = (state != IDLE);
    assign sout_valid = busy;
    assign sof        = (state == SHIFT) && (bit_cnt == '0);
    assign p2s_ready  = !hold_vld;
    assign overflow   = ovf;

`ifdef P2S_PARITY_EN
    assign sout = (state == SHIFT) ? data_bit :
                  (state == PAR)   ? par_bit  : 1'b0;
`else
    assign sout = (state == SHIFT) ? data_bit : 1'b0;
`endif

endmodule

// File: tb/tb_prng_p2s.sv
// Bench for prng_p2s: two instances (CLK_DIV=1 MSB first, CLK_DIV=4 LSB first)
// share one stimulus stream; an occupancy model predicts accepted words and
// queues the expected per-cycle serial stream, a monitor pops and compares.
module tb_prng_p2s;

    localparam int W    = 32;
`ifdef P2S_PARITY_EN
    localparam int FB   = W + 1;
`else
    localparam int FB   = W;
`endif
    localparam int DIV0 = 1;
    localparam int DIV1 = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din_valid = 1'b0;
    logic [W-1:0] din = '0;

    logic [1:0] p2s_ready;
    logic [1:0] sout;
    logic [1:0] sout_valid;
    logic [1:0] sof;
    logic [1:0] busy;
    logic [1:0] overflow;

    always #5 clk = ~clk;

    prng_p2s #(.WIDTH(W), .CLK_DIV(DIV0), .MSB_FIRST(1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .p2s_ready  (p2s_ready[0]),
        .sout       (sout[0]),
        .sout_valid (sout_valid[0]),
        .sof        (sof[0]),
        .busy       (busy[0]),
        .overflow   (overflow[0])
    );

    prng_p2s #(.WIDTH(W), .CLK_DIV(DIV1), .MSB_FIRST(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .p2s_ready  (p2s_ready[1]),
        .sout       (sout[1]),
        .sout_valid (sout_valid[1]),
        .sof        (sof[1]),
        .busy       (busy[1]),
        .overflow   (overflow[1])
    );

    // Reference model: cycles left in the current frame, one buffered word,
    // sticky drop flag, and a queue of expected {sof, sout} per cycle.
    int           rem [2];
    bit           hold [2];
    logic [W-1:0] hold_w [2];
    bit           ovf [2];
    logic [1:0]   q0 [$];
    logic [1:0]   q1 [$];
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;

    function automatic int div_of(input int k);
        return (k == 0) ? DIV0 : DIV1;
    endfunction

    task automatic push_frame(input int k, input logic [W-1:0] w);
        logic       b;
        logic [1:0] e;
        for (int i = 0; i < FB; i++) begin
            if (i == W)      b = ^w;
            else if (k == 0) b = w[W-1-i];
            else             b = w[i];
            e = {(i == 0), b};
            for (int c = 0; c < div_of(k); c++) begin
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rem[k]  = 0;
                hold[k] = 1'b0;
                ovf[k]  = 1'b0;
                if (k == 0) q0.delete();
                else        q1.delete();
            end else if (rem[k] == 0) begin
                if (din_valid) begin
                    push_frame(k, din);
                    rem[k] = FB * div_of(k);
                end
            end else if (rem[k] == 1) begin
                if (hold[k]) begin
                    push_frame(k, hold_w[k]);
                    rem[k]  = FB * div_of(k);
                    hold[k] = 1'b0;
                    if (din_valid) ovf[k] = 1'b1;
                end else if (din_valid) begin
                    push_frame(k, din);
                    rem[k] = FB * div_of(k);
                end else begin
                    rem[k] = 0;
                end
            end else begin
                rem[k] = rem[k] - 1;
                if (din_valid) begin
                    if (hold[k]) begin
                        ovf[k] = 1'b1;
                    end else begin
                        hold[k]   = 1'b1;
                        hold_w[k] = din;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %b expected %b at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] w);
        rst       = r;
        din_valid = v;
        din       = w;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    // Monitor on the falling edge, half a cycle clear of the sampling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [1:0] e;
                bit         empty;
                chk("p2s_ready", k, p2s_ready[k], !hold[k]);
                chk("overflow", k, overflow[k], ovf[k]);
                chk("sout_valid", k, sout_valid[k], rem[k] != 0);
                chk("busy", k, busy[k], rem[k] != 0);
                empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
                if (rem[k] != 0) begin
                    checks++;
                    if (empty) begin
                        errors++;
                        $display("FAIL stream inst%0d serial bit present but none expected at %0t", k, $time);
                    end else begin
                        if (k == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("sout", k, sout[k], e[0]);
                        chk("sof", k, sof[k], e[1]);
                    end
                end else begin
                    chk("sout_idle", k, sout[k], 1'b0);
                    chk("sof_idle", k, sof[k], 1'b0);
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; hold[k] = 1'b0; hold_w[k] = '0; ovf[k] = 1'b0;
        end
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        mon_en = 1'b1;
        idle(2);

        // Single word, ones at both ends.
        step(1'b0, 1'b1, 32'h8000_0001);
        idle(140);

        // Second word buffered mid-frame, third dropped while buffer full.
        step(1'b0, 1'b1, 32'hAAAA_AAAA);
        idle(5);
        step(1'b0, 1'b1, 32'h0000_FFFF);
        idle(3);
        step(1'b0, 1'b1, 32'hDEAD_BEEF);
        idle(270);

        // LSB-first slow instance: 0x2 gives 0 then 1 over 4-cycle bits.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0002);
        idle(140);

        // Strobe exactly in the last cycle of a fast frame (direct reload).
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0F0F_0F0F);
        idle(FB - 1);
        step(1'b0, 1'b1, 32'h1357_2468);
        idle(300);

        // Strobe in the drain cycle of the fast instance: must be dropped.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'hCAFE_0001);
        step(1'b0, 1'b1, 32'hCAFE_0002);
        idle(FB - 2);
        step(1'b0, 1'b1, 32'hCAFE_0003);
        idle(300);

        // Reset in the middle of a frame, then a clean frame.
        step(1'b0, 1'b1, 32'h1111_1111);
        idle(10);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h1234_5678);
        idle(140);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0)
                step(1'b1, 1'b0, '0);
            else
                step(1'b0, ($urandom_range(0, 19) == 0), $urandom);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) begin
            idle(1);
        end
        idle(2);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain expected bits left inst0=%0d inst1=%0d required 0", q0.size(), q1.size());
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
